// File: rtl/prog_counter_pkg.sv
// Shared definitions for the fetch-stage program counter: state encoding, default
// PC width and the branch-target table.
package prog_counter_pkg;

  localparam int PC_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

  localparam logic [PC_W_DEFAULT-1:0] kJumpTarg [4] = '{
    10'h040,
    10'h123,
    10'h2A5,
    10'h3F7
  };

endpackage

// File: rtl/prog_counter_target_lut.sv
// Branch-target lookup: 2-bit decoder index to a PC_W-wide jump target.
// Table entries are resized to PC_W, so narrow PCs keep the low bits.
module target_lut
  import prog_counter_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic [1:0]      i_sel,
  output logic [PC_W-1:0] o_targ
);

  logic [PC_W_DEFAULT-1:0] w_raw;

  assign w_raw  = kJumpTarg[i_sel];
  assign o_targ = PC_W'(w_raw);

endmodule

// File: rtl/prog_counter.sv
// Fetch-stage program counter with IDLE/LOAD/RUN/HALT sequencing and je/jne redirect.
// Optional RUN-cycle counter (CycleCt port) built when CYCLE_COUNT_EN is defined.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
`ifdef CYCLE_COUNT_EN
  ,parameter int CNT_W = 16
`endif
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             JumpEqual,
  input  logic             JumpNotEqual,
  input  logic [1:0]       TargSel,
  input  logic             EqualFlag,
  input  logic             Ack,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done
`ifdef CYCLE_COUNT_EN
  ,output logic [CNT_W-1:0] CycleCt
`endif
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_targ;
  logic            r_running;
  logic            r_done;
  logic            w_running_nxt;
  logic            w_done_nxt;
  logic            w_taken;

  target_lut #(
    .PC_W (PC_W)
  ) u_target_lut (
    .i_sel  (TargSel),
    .o_targ (w_targ)
  );

  // An illegal je+jne encoding resolves as je alone.
  assign w_taken = JumpEqual ? EqualFlag : (JumpNotEqual & ~EqualFlag);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (Start) w_state_nxt = S_LOAD;
      S_LOAD: if (!Start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (Start) begin
          w_state_nxt = S_LOAD;
        end else if (Ack) begin
          w_state_nxt = S_HALT;
        end
      end
      S_HALT: if (Start) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pc_nxt = r_pc;
    case (r_state)
      S_IDLE: if (Start) w_pc_nxt = '0;
      S_LOAD: w_pc_nxt = '0;
      S_RUN: begin
        // Halt freezes the PC and wins over any jump in the same instruction.
        if (Start) begin
          w_pc_nxt = '0;
        end else if (Ack) begin
          w_pc_nxt = r_pc;
        end else if (w_taken) begin
          w_pc_nxt = w_targ;
        end else begin
          w_pc_nxt = r_pc + 1'b1;
        end
      end
      S_HALT: if (Start) w_pc_nxt = '0;
      default: w_pc_nxt = '0;
    endcase
    w_running_nxt = (w_state_nxt == S_RUN);
    w_done_nxt    = (w_state_nxt == S_HALT);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc      <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_running <= w_running_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign ProgCtr = r_pc;
  assign Running = r_running;
  assign Done    = r_done;

`ifdef CYCLE_COUNT_EN
  logic [CNT_W-1:0] r_cyc;

  // Counts every cycle spent in RUN, including the Ack cycle; saturates at all-ones.
  always_ff @(posedge Clk) begin
    if (Reset || (r_state == S_LOAD) || (w_state_nxt == S_LOAD)) begin
      r_cyc <= '0;
    end else if ((r_state == S_RUN) && (r_cyc != '1)) begin
      r_cyc <= r_cyc + 1'b1;
    end
  end

  assign CycleCt = r_cyc;
`endif

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: a 10-bit PC instance and a 4-bit PC instance.
// Expected outputs are queued per cycle and checked by an independent monitor.
module tb_prog_counter;

  logic       Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       rst, st, je, jne, ef, ack;
  logic [1:0] ts;
  logic       s_rst, s_st, s_je, s_jne, s_ef, s_ack;
  logic [1:0] s_ts;

  logic [9:0] pc10;
  logic       run10, done10;
  logic [3:0] pc4;
  logic       run4, done4;
`ifdef CYCLE_COUNT_EN
  logic [15:0] cyc10;
  logic [3:0]  cyc4;
`endif

  prog_counter #(
    .PC_W (10)
`ifdef CYCLE_COUNT_EN
    ,.CNT_W (16)
`endif
  ) u_dut (
    .Clk          (Clk),
    .Reset        (rst),
    .Start        (st),
    .JumpEqual    (je),
    .JumpNotEqual (jne),
    .TargSel      (ts),
    .EqualFlag    (ef),
    .Ack          (ack),
    .ProgCtr      (pc10),
    .Running      (run10),
    .Done         (done10)
`ifdef CYCLE_COUNT_EN
    ,.CycleCt     (cyc10)
`endif
  );

  prog_counter #(
    .PC_W (4)
`ifdef CYCLE_COUNT_EN
    ,.CNT_W (4)
`endif
  ) u_small (
    .Clk          (Clk),
    .Reset        (s_rst),
    .Start        (s_st),
    .JumpEqual    (s_je),
    .JumpNotEqual (s_jne),
    .TargSel      (s_ts),
    .EqualFlag    (s_ef),
    .Ack          (s_ack),
    .ProgCtr      (pc4),
    .Running      (run4),
    .Done         (done4)
`ifdef CYCLE_COUNT_EN
    ,.CycleCt     (cyc4)
`endif
  );

  typedef struct {
    int          sel;
    string       nm;
    logic [15:0] pc;
    logic        run;
    logic        dn;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Monitor: one queued expectation per clock, sampled 1ns after the edge.
  initial begin : monitor
    exp_t        e;
    logic [15:0] a_pc;
    logic        a_run, a_dn;
    logic [15:0] a_cyc;
    logic        bad;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e     = q.pop_front();
        a_pc  = (e.sel == 1) ? {12'b0, pc4} : {6'b0, pc10};
        a_run = (e.sel == 1) ? run4 : run10;
        a_dn  = (e.sel == 1) ? done4 : done10;
        a_cyc = 16'd0;
`ifdef CYCLE_COUNT_EN
        a_cyc = (e.sel == 1) ? {12'b0, cyc4} : cyc10;
`endif
        bad = (a_pc !== e.pc) || (a_run !== e.run) || (a_dn !== e.dn);
`ifdef CYCLE_COUNT_EN
        if (a_cyc !== 16'(e.cyc)) bad = 1'b1;
`endif
        n_chk++;
        if (bad) begin
          n_fail++;
          $display("FAIL %s: got pc=%0d run=%0b done=%0b cyc=%0d, expected pc=%0d run=%0b done=%0b cyc=%0d",
                   e.nm, a_pc, a_run, a_dn, a_cyc, e.pc, e.run, e.dn, e.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge with inputs already set; queues the state expected after the next posedge.
  task automatic tick(input string nm, input int sel, input int pc, input bit run,
                      input bit dn, input int cyc);
    exp_t e;
    e.sel = sel;
    e.nm  = nm;
    e.pc  = 16'(pc);
    e.run = run;
    e.dn  = dn;
    e.cyc = cyc;
    q.push_back(e);
    @(negedge Clk);
  endtask

  task automatic clr_main();
    st = 1'b0; je = 1'b0; jne = 1'b0; ef = 1'b0; ack = 1'b0; ts = 2'd0;
  endtask

  task automatic clr_small();
    s_st = 1'b0; s_je = 1'b0; s_jne = 1'b0; s_ef = 1'b0; s_ack = 1'b0; s_ts = 2'd0;
  endtask

  // Start pulse, then run n plain instructions from address 0.
  task automatic run_to(input int sel, input int n);
    int pmod;
    int cmax;
    pmod = (sel == 1) ? 16 : 1024;
    cmax = (sel == 1) ? 15 : 65535;
    if (sel == 1) begin clr_small(); s_st = 1'b1; end
    else begin clr_main(); st = 1'b1; end
    tick("run_to_load", sel, 0, 1'b0, 1'b0, 0);
    if (sel == 1) s_st = 1'b0; else st = 1'b0;
    tick("run_to_entry", sel, 0, 1'b1, 1'b0, 0);
    for (int i = 1; i <= n; i++) begin
      tick("run_to_step", sel, i % pmod, 1'b1, 1'b0, (i > cmax) ? cmax : i);
    end
  endtask

  initial begin : stimulus
    clr_main();
    clr_small();
    rst   = 1'b1;
    s_rst = 1'b1;
    st    = 1'b1;
    @(negedge Clk);

    // Reset dominates Start
    tick("reset_1", 0, 0, 1'b0, 1'b0, 0);
    tick("reset_2", 0, 0, 1'b0, 1'b0, 0);
    rst = 1'b0; st = 1'b0;
    tick("idle_hold", 0, 0, 1'b0, 1'b0, 0);

    // Start held three cycles, jump inputs ignored while loading
    st = 1'b1; je = 1'b1; ef = 1'b1; ts = 2'd2;
    tick("load_ignore_jump_1", 0, 0, 1'b0, 1'b0, 0);
    tick("load_ignore_jump_2", 0, 0, 1'b0, 1'b0, 0);
    tick("load_ignore_jump_3", 0, 0, 1'b0, 1'b0, 0);
    clr_main();
    tick("run_entry", 0, 0, 1'b1, 1'b0, 0);
    tick("seq_1", 0, 1, 1'b1, 1'b0, 1);
    tick("seq_2", 0, 2, 1'b1, 1'b0, 2);
    tick("seq_3", 0, 3, 1'b1, 1'b0, 3);

    // Branch decisions at PC=5
    run_to(0, 5);
    je = 1'b1; ef = 1'b1; ts = 2'd2;
    tick("je_taken", 0, 'h2A5, 1'b1, 1'b0, 6);
    clr_main();
    tick("after_jump", 0, 'h2A6, 1'b1, 1'b0, 7);

    run_to(0, 5);
    je = 1'b1; ef = 1'b0; ts = 2'd2;
    tick("je_not_taken", 0, 6, 1'b1, 1'b0, 6);

    run_to(0, 5);
    jne = 1'b1; ef = 1'b0; ts = 2'd1;
    tick("jne_taken", 0, 'h123, 1'b1, 1'b0, 6);

    run_to(0, 5);
    jne = 1'b1; ef = 1'b1; ts = 2'd1;
    tick("jne_not_taken", 0, 6, 1'b1, 1'b0, 6);

    run_to(0, 5);
    je = 1'b1; jne = 1'b1; ef = 1'b0; ts = 2'd3;
    tick("illegal_both", 0, 6, 1'b1, 1'b0, 6);

    // Halt beats a taken jump, then holds
    run_to(0, 9);
    ack = 1'b1; je = 1'b1; ef = 1'b1; ts = 2'd2;
    tick("halt_entry", 0, 9, 1'b0, 1'b1, 10);
    ack = 1'b0;
    for (int i = 0; i < 10; i++) tick("halt_hold", 0, 9, 1'b0, 1'b1, 10);
    clr_main();
    st = 1'b1;
    tick("halt_restart", 0, 0, 1'b0, 1'b0, 0);
    st = 1'b0;
    tick("run_after_halt", 0, 0, 1'b1, 1'b0, 0);

    // 20 RUN cycles then Ack
    for (int i = 1; i <= 20; i++) tick("count_run", 0, i, 1'b1, 1'b0, i);
    ack = 1'b1;
    tick("count_ack", 0, 20, 1'b0, 1'b1, 21);
    ack = 1'b0;
    for (int i = 0; i < 3; i++) tick("count_frozen", 0, 20, 1'b0, 1'b1, 21);

    // Start during RUN restarts and outranks Ack
    run_to(0, 2);
    st = 1'b1; ack = 1'b1;
    tick("start_over_ack", 0, 0, 1'b0, 1'b0, 0);
    clr_main();
    tick("restart_run", 0, 0, 1'b1, 1'b0, 0);

    // 4-bit instance: wrap, saturation, truncated LUT target, reset mid-run
    tick("small_reset", 1, 0, 1'b0, 1'b0, 0);
    s_rst = 1'b0;
    run_to(1, 20);
    s_je = 1'b1; s_ef = 1'b1; s_ts = 2'd2;
    tick("lut_trunc", 1, 5, 1'b1, 1'b0, 15);
    clr_small();

    run_to(1, 7);
    s_rst = 1'b1;
    tick("reset_mid_run", 1, 0, 1'b0, 1'b0, 0);
    s_rst = 1'b0;
    tick("idle_after_reset_1", 1, 0, 1'b0, 1'b0, 0);
    tick("idle_after_reset_2", 1, 0, 1'b0, 1'b0, 0);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
